// File: rtl/fsk_byte_receiver.sv
// FSK byte receiver: boxcar-averages period samples, slices them against a
// compare point and recovers UART-style frames into a one-entry output holding register.
module fsk_byte_receiver #(
  parameter int AVG_LOG2        = 2,
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic        clk_200M,
  input  logic        reset_n_200M,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  input  logic [15:0] compare_point_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        level_o,
  output logic        framing_error_o,
  output logic        overrun_o
);

  localparam int            N_TAPS   = 1 << AVG_LOG2;
  localparam int            SUM_W    = 16 + AVG_LOG2;
  localparam logic [7:0]    CNT_HALF = 8'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [7:0]    CNT_BIT  = 8'(SAMPLES_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Boxcar filter
  logic [15:0]      r_hist [N_TAPS];
  logic [SUM_W-1:0] r_sum;
  logic             r_sum_stb;
  logic [SUM_W-1:0] w_sum_next;
  logic [15:0]      w_avg;

  assign w_sum_next = r_sum + SUM_W'(sample_i) - SUM_W'(r_hist[N_TAPS-1]);
  assign w_avg      = 16'(r_sum >> AVG_LOG2);

  // NOTE: the history is reset because the running sum assumes it starts at zero;
  // an unreset history would leave the sum permanently offset.
  always_ff @(posedge clk_200M or negedge reset_n_200M) begin
    if (!reset_n_200M) begin
      for (int i = 0; i < N_TAPS; i++) r_hist[i] <= '0;
      r_sum     <= '0;
      r_sum_stb <= 1'b0;
    end else begin
      r_sum_stb <= sample_valid_i;
      if (sample_valid_i) begin
        r_sum     <= w_sum_next;
        r_hist[0] <= sample_i;
        for (int i = 1; i < N_TAPS; i++) r_hist[i] <= r_hist[i-1];
      end
    end
  end

  // Slicer: shorter period means higher frequency, which is mark
  logic r_level;
  logic r_lvl_stb;

  always_ff @(posedge clk_200M or negedge reset_n_200M) begin
    if (!reset_n_200M) begin
      r_level   <= 1'b1;
      r_lvl_stb <= 1'b0;
    end else begin
      r_lvl_stb <= r_sum_stb;
      if (r_sum_stb) r_level <= (w_avg < compare_point_i);
    end
  end

  assign level_o = r_level;

  // Frame recovery and output holding register
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic [7:0] r_byte;
  logic       r_byte_valid;
  logic       r_framing_error;
  logic       r_overrun;

  logic w_stop_sample;
  logic w_byte_done;
  logic w_frame_bad;
  logic w_handshake;

  assign w_stop_sample = r_lvl_stb && (r_state == S_STOP) && (r_cnt == CNT_BIT);
  assign w_byte_done   = w_stop_sample && r_level;
  assign w_frame_bad   = w_stop_sample && !r_level;
  assign w_handshake   = r_byte_valid && byte_ready_i;

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values of r_state/r_cnt, exactly as the combinational decodes above do.
  always_ff @(posedge clk_200M or negedge reset_n_200M) begin
    if (!reset_n_200M) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_byte          <= '0;
      r_byte_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_framing_error <= w_frame_bad;
      r_overrun       <= w_byte_done && r_byte_valid && !byte_ready_i;

      if (w_byte_done && (!r_byte_valid || byte_ready_i)) begin
        r_byte       <= r_shift;
        r_byte_valid <= 1'b1;
      end else if (w_handshake) begin
        r_byte_valid <= 1'b0;
      end

      if (r_lvl_stb) begin
        unique case (r_state)
          S_IDLE: begin
            if (!r_level) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end
          end
          S_START: begin
            if (r_cnt == CNT_HALF) begin
              r_cnt <= '0;
              r_idx <= '0;
              r_state <= r_level ? S_IDLE : S_DATA;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          S_DATA: begin
            if (r_cnt == CNT_BIT) begin
              r_cnt          <= '0;
              r_shift[r_idx] <= r_level;
              r_idx          <= r_idx + 3'd1;
              if (r_idx == 3'd7) r_state <= S_STOP;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          S_STOP: begin
            if (r_cnt == CNT_BIT) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign byte_o          = r_byte;
  assign byte_valid_o    = r_byte_valid;
  assign framing_error_o = r_framing_error;
  assign overrun_o       = r_overrun;

endmodule

// File: doc/fsk_byte_receiver.md
# fsk_byte_receiver

Downstream of the frequency counter in the FM receive path. Takes the 16-bit period samples produced at ~1 MSPS and smooths them with a boxcar average. Slices each average against a compare point into a mark/space level, then recovers UART-style frames (start, 8 data LSB-first, stop) into bytes. Bytes are presented on a valid/ready output with overrun and framing-error flags.

## Interface
Parameters:
- AVG_LOG2, 2, log2 of boxcar length; averages 2**AVG_LOG2 samples (legal 0..4)
- SAMPLES_PER_BIT, 16, period samples per data bit (legal 4..255)

Ports:
- clk_200M  input  1  reference clock; all logic on its rising edge
- reset_n_200M  input  1  asynchronous, active-low reset
- sample_i  input  16  period count (reference cycles per measurement window)
- sample_valid_i  input  1  one-cycle strobe; sample_i valid this cycle
- compare_point_i  input  16  slicing threshold; quasi-static
- byte_o  output  8  received byte
- byte_valid_o  output  1  byte_o holds an unconsumed byte
- byte_ready_i  input  1  consumer accepts byte_o when high with byte_valid_o
- level_o  output  1  registered sliced level (1 = mark = frequency above centre)
- framing_error_o  output  1  one-cycle pulse: stop bit read as 0
- overrun_o  output  1  one-cycle pulse: byte completed while holding register full

## Operation
- Filter: shift register of 2**AVG_LOG2 samples plus running sum of width 16+AVG_LOG2.
  - On each sample_valid_i: sum ← sum + sample_i − oldest sample, then shift.
  - Average = sum >> AVG_LOG2, truncated.
  - History resets to 0, so the average starts at 0, which reads as mark/idle.
- Slicer: level = (average < compare_point_i). Equality gives 0 (space). Lower period means higher frequency, which gives 1.
- Bit clock: the FSM advances only on the internal strobe lvl_stb. A sample counter cnt (8 bits) counts lvl_stb events.
- FSM states:
  - IDLE: on lvl_stb with level=0, go to START with cnt=0.
  - START: at cnt = SAMPLES_PER_BIT/2 − 1 (integer division), sample level. If level=0, go to DATA with cnt=0, bit index 0. If level=1, it was a glitch; return to IDLE with no flag.
  - DATA: at cnt = SAMPLES_PER_BIT − 1, shift level into bit[index] (LSB first) and reset cnt. After index 7, go to STOP.
  - STOP: at cnt = SAMPLES_PER_BIT − 1, sample level. If 1, the byte is complete. If 0, pulse framing_error_o and discard the byte. Both cases go to IDLE.
  - Every other lvl_stb increments cnt.
- Output holding register (one entry):
  - Consumer handshake: byte_valid_o & byte_ready_i clears byte_valid_o.
  - Byte completes while byte_valid_o=0: load byte_o and set byte_valid_o.
  - Byte completes in the same cycle as a handshake: load the new byte and keep byte_valid_o=1.
  - Byte completes while byte_valid_o=1 and byte_ready_i=0: pulse overrun_o, drop the new byte, leave byte_o unchanged.
- compare_point_i changes take effect on the next slice. No re-synchronisation of frames.

## Timing
- Reset values: byte_o=0, byte_valid_o=0, level_o=1, framing_error_o=0, overrun_o=0, FSM=IDLE, cnt=0, sum=0, history=0.
- sample_valid_i at edge t → sum/history updated at edge t+1.
- Level registered and lvl_stb asserted (one cycle) at edge t+2. level_o updates with it.
- Byte completion is decided on the lvl_stb cycle of the stop sample. byte_valid_o, framing_error_o and overrun_o update at the following edge, so total latency is 3 cycles from the stop-bit sample_valid_i.
- sample_valid_i on consecutive cycles is legal. The pipeline accepts one sample per cycle.
- Asserting reset mid-frame aborts the frame immediately. Any held byte is lost, and no flags pulse on release.
- byte_ready_i is sampled every cycle. There is no combinational path from byte_ready_i to any output.

## Test plan
- Use AVG_LOG2=2, SPB=16, compare_point_i=200; mark = 190, space = 210. Send frame 0xA5 with byte_ready_i=1 → byte_valid_o high for 1 cycle, byte_o=0xA5, no flags.
- Single 210 sample amid 190s → average 195, level stays 1, FSM stays IDLE, no byte.
- Frame 0x3C with a space stop bit → framing_error_o pulses once, byte_valid_o stays 0, next good frame 0x55 received correctly.
- Two frames 0x11 and 0x22 with byte_ready_i=0 → byte_o=0x11 held, overrun_o pulses once at the second completion. Then raise byte_ready_i → byte_valid_o clears.
- Four samples of exactly 200 → level_o=0 (equality is space). Then 190s → level_o returns to 1 after the average drops below 200.
- Reset pulse after data bit 3 of a frame → all outputs at reset values. A following complete frame 0xF0 is received correctly.
